// File: rtl/mandel_hdmi_pkg.sv
// Shared definitions for the Mandelbrot-to-HDMI path: frame size, writedata layout, RGB332 map, write FSM states.
package mandel_hdmi_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  localparam int X_MSB   = 27;
  localparam int X_LSB   = 18;
  localparam int Y_MSB   = 17;
  localparam int Y_LSB   = 8;
  localparam int RGB_MSB = 7;
  localparam int PIX_W   = X_MSB + 1;

  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } wr_state_t;

  // Low count bits vary fastest, so they land in red for strong banding.
  function automatic logic [RGB_MSB:0] rgb332(input logic [7:0] it);
    return {it[R_W-1:0], it[R_W+G_W-1:R_W], it[R_W+G_W+B_W-1:R_W+G_W]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data: rd_data updates on the edge that pops and then holds.
// Caller must not push when full nor pop when empty.
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/mandel_pixel_writer.sv
// Colours Mandelbrot results and drains them as Avalon-MM writes, holding writedata WR_HOLD cycles after each.
// Pixel to avm_write is 2 cycles when idle; a stalled slave fills the FIFO and drops pix_ready.
module mandel_pixel_writer
  import mandel_hdmi_pkg::*;
#(
  parameter int ITER_W     = 8,
  parameter int MAX_ITER   = 255,
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_HOLD    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  input  logic [9:0]                      pix_x,
  input  logic [9:0]                      pix_y,
  input  logic [ITER_W-1:0]               pix_iter,
  output logic                            avm_write,
  output logic [31:0]                     avm_writedata,
  input  logic                            avm_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            frame_done,
  output logic [15:0]                     drop_cnt
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  logic             hs, in_range, push, pop, accept;
  logic             fifo_full, fifo_empty;
  logic [7:0]       rgb;
  logic [PIX_W-1:0] head;
  logic [LVL_W-1:0] level_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  wr_state_t        state, state_nxt;

  assign hs       = pix_valid & pix_ready;
  assign in_range = (pix_x < 10'(H_RES)) && (pix_y < 10'(V_RES));
  assign push     = hs & in_range & ~fifo_full;
  assign rgb      = (pix_iter >= ITER_W'(MAX_ITER)) ? 8'h00 : rgb332(pix_iter[7:0]);

  // The FIFO's registered read port doubles as the writedata register.
  sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({pix_x, pix_y, rgb}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign avm_writedata = {4'h0, head};
  assign avm_write     = (state == ST_WRITE);
  assign level_nxt     = fifo_level + LVL_W'(push) - LVL_W'(pop);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: if (!avm_waitrequest) begin
        accept    = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: if (hold_cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      pix_ready  <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      pix_ready <= (level_nxt != LVL_W'(FIFO_DEPTH));
      if (accept)
        hold_cnt <= HOLD_W'(WR_HOLD - 1);
      else if (state == ST_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
      frame_done <= accept && (head[X_MSB:X_LSB] == 10'(H_RES - 1))
                           && (head[Y_MSB:Y_LSB] == 10'(V_RES - 1));
      if (hs && !in_range && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mandel_pixel_writer.sv
// Bench for mandel_pixel_writer: vector table, directed stall/reset/push-pop sequences, random traffic vs a scoreboard.
module tb_mandel_pixel_writer;

  localparam int H = 640;
  localparam int V = 480;
  localparam int WRH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [7:0]  pix_iter = '0;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [4:0]  fifo_level;
  logic        frame_done;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mandel_pixel_writer dut (
    .clk             (clk),
    .rst             (rst),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_iter        (pix_iter),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .fifo_level      (fifo_level),
    .frame_done      (frame_done),
    .drop_cnt        (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: got %s", name, what);
  endtask

  // Reference colour map from the arithmetic definition of RGB332 fields.
  function automatic logic [31:0] model_word(input int x, input int y, input int it);
    int rgb;
    if (it >= 255) rgb = 0;
    else rgb = (it % 8) * 32 + ((it / 8) % 8) * 4 + (it / 64) % 4;
    return 32'(x * 262144 + y * 256 + rgb);
  endfunction

  // Scoreboard and protocol monitor, sampling on the falling edge.
  logic [31:0] exp_q[$];
  int          acc_cyc[$];
  int          model_drop = 0, writes = 0, fd_pulses = 0, cyc = 0, hold_left = 0;
  bit          chk_en = 0, fd_exp = 0, pending = 0;
  logic [31:0] hold_wd, prev_wd, want;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_pulses++;
      chk("drop_cnt", 32'(drop_cnt), 32'(model_drop));
      if (hold_left > 0) begin
        chk("hold_write_low", 32'(avm_write), 32'd0);
        chk("hold_wd", avm_writedata, hold_wd);
        hold_left--;
      end
      if (pending && avm_write) chk("wd_stable", avm_writedata, prev_wd);
      fd_exp = 0;
      if (rst) begin
        exp_q.delete();
        model_drop = 0;
        hold_left = 0;
        pending = 0;
      end else begin
        if (pix_valid && pix_ready) begin
          if (pix_x < 10'(H) && pix_y < 10'(V)) exp_q.push_back(model_word(int'(pix_x), int'(pix_y), int'(pix_iter)));
          else if (model_drop < 65535) model_drop++;
        end
        if (avm_write && !avm_waitrequest) begin
          writes++;
          acc_cyc.push_back(cyc);
          pending = 0;
          if (exp_q.size() == 0) begin
            fail("write_unexpected", "write with nothing queued");
          end else begin
            want = exp_q.pop_front();
            chk("write_data", avm_writedata, want);
            fd_exp = (want[27:18] == 10'(H - 1)) && (want[17:8] == 10'(V - 1));
            hold_left = WRH;
            hold_wd = want;
          end
        end else begin
          pending = avm_write;
          prev_wd = avm_writedata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_drain(input int lim);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || avm_write) && k < lim) begin
      tick();
      k++;
    end
    if (k >= lim) fail("drain_timeout", "entries still queued");
    ticks(WRH + 2);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input int x, input int y, input int it);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_iter = 8'(it);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
  endtask

  typedef struct {
    int          x;
    int          y;
    int          it;
    logic [31:0] wd;
    bit          drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, d0, n_acc, r;
    bit got;

    tbl[0] = '{10,  20,  5,   32'h002814A0, 1'b0};
    tbl[1] = '{639, 479, 255, 32'h09FDDF00, 1'b0};
    tbl[2] = '{640, 0,   5,   32'h00000000, 1'b1};
    tbl[3] = '{0,   480, 5,   32'h00000000, 1'b1};
    tbl[4] = '{1,   1,   254, 32'h000401DF, 1'b0};
    tbl[5] = '{100, 200, 71,  32'h0190C8E1, 1'b0};
    tbl[6] = '{320, 240, 128, 32'h0500F002, 1'b0};

    tick();
    chk("rst_ready", 32'(pix_ready), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_wd", avm_writedata, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(pix_ready), 32'd1);
    chk_en = 1;

    foreach (tbl[i]) begin
      w0 = writes;
      d0 = int'(drop_cnt);
      send(tbl[i].x, tbl[i].y, tbl[i].it);
      chk("lat_n1", 32'(avm_write), 32'd0);
      tick();
      if (tbl[i].drop) begin
        ticks(4);
        chk("drop_no_write", 32'(writes), 32'(w0));
        chk("drop_inc", 32'(drop_cnt), 32'(d0 + 1));
        chk("drop_level", 32'(fifo_level), 32'd0);
      end else begin
        chk("lat_n2", 32'(avm_write), 32'd1);
        chk("tbl_wd", avm_writedata, tbl[i].wd);
        ticks(8);
        chk("tbl_one_write", 32'(writes), 32'(w0 + 1));
      end
    end
    chk("frame_done_pulses", 32'(fd_pulses), 32'd1);
    chk("drop_total", 32'(drop_cnt), 32'd2);

    // Stalled slave: one pixel parks in the write register, sixteen fill the FIFO.
    avm_waitrequest = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      pix_x = 10'($urandom_range(0, 639));
      pix_y = 10'($urandom_range(0, 479));
      pix_iter = 8'($urandom);
      pix_valid = 1'b1;
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
        got = pix_ready;
        tick();
      end
      if (got) n_acc++;
    end
    pix_valid = 1'b0;
    ticks(5);
    chk("stall_accepted", 32'(n_acc), 32'd17);
    chk("stall_level", 32'(fifo_level), 32'd16);
    chk("stall_ready", 32'(pix_ready), 32'd0);
    chk("stall_write", 32'(avm_write), 32'd1);
    acc_cyc.delete();
    avm_waitrequest = 1'b0;
    wait_drain(300);
    chk("drain_count", 32'(acc_cyc.size()), 32'd17);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("drain_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(WRH + 2));

    // Reset while a write is pending and five entries are queued.
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) send(10 + i, 30, 40 + i);
    tick();
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    chk("pre_rst_write", 32'(avm_write), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_write", 32'(avm_write), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    chk("mid_rst_wd", avm_writedata, 32'd0);
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    w0 = writes;
    ticks(20);
    chk("no_stale_write", 32'(writes), 32'(w0));
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_ready", 32'(pix_ready), 32'd1);

    // Push and pop on the same edge at level 8.
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 9; i++) send(50 + i, 60, 100 + i);
    tick();
    chk("pp_level_start", 32'(fifo_level), 32'd8);
    avm_waitrequest = 1'b0;
    tick();
    avm_waitrequest = 1'b1;
    chk("pp_accepted", 32'(avm_write), 32'd0);
    ticks(3);
    chk("pp_level_idle", 32'(fifo_level), 32'd8);
    chk("pp_write_idle", 32'(avm_write), 32'd0);
    send(77, 88, 99);
    chk("pp_level_same", 32'(fifo_level), 32'd8);
    chk("pp_write_again", 32'(avm_write), 32'd1);
    avm_waitrequest = 1'b0;
    wait_drain(300);

    // Random traffic, including out-of-range coordinates and the last pixel of the frame.
    for (int c = 0; c < 800; c++) begin
      r = int'($urandom_range(0, 9));
      pix_valid = 1'($urandom_range(0, 1));
      pix_x = (r == 0) ? 10'(H - 1) : 10'($urandom_range(0, 700));
      pix_y = (r == 0) ? 10'(V - 1) : 10'($urandom_range(0, 520));
      pix_iter = 8'($urandom);
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      tick();
    end
    pix_valid = 1'b0;
    avm_waitrequest = 1'b0;
    wait_drain(600);
    chk("final_level", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
